// File: rtl/ctrl_pkg.sv
// Shared control types for the RV32I pipelined control unit.
// Opcodes, control enums, the stage bundle and the ALU op helper.
package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam int ALU_OP_W = 4;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } res_src_e;

   typedef struct packed {
      logic       RegWrite;
      res_src_e   ResultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Jalr;
      logic       Branch;
      alu_op_e    ALUControl;
      logic       ALUSrcA;
      logic       ALUSrcB;
      logic [2:0] funct3;
      logic       Illegal;
   } ctrl_bundle_t;

   // alt picks sub for funct3=000 and sra for funct3=101
   function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt);
      alu_op_e op;
      unique case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// RV32I instruction-field decode into a control bundle (combinational).
// CTRL_ILLEGAL_TRAP_EN: when defined, the Illegal bit is raised in the bundle.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0]   i_OpCode,
   input  logic [2:0]   i_funct3,
   input  logic         i_funct7_5,
   output ctrl_bundle_t o_Ctrl,
   output logic [2:0]   o_ImmSrc,
   output logic         o_UsesRs1,
   output logic         o_UsesRs2
);

   ctrl_bundle_t w_c;
   imm_src_e     w_imm;
   logic         w_rs1;
   logic         w_rs2;
   logic         w_ill;

   // Opcode class decode; illegal encodings collapse to an all-zero bundle
   always_comb begin
      w_c        = '0;
      w_c.funct3 = i_funct3;
      w_imm      = IMM_I;
      w_rs1      = 1'b0;
      w_rs2      = 1'b0;
      w_ill      = 1'b0;
      unique case (i_OpCode)
         OP_OP: begin
            w_c.RegWrite   = 1'b1;
            w_c.ALUControl = alu_decode(i_funct3, i_funct7_5);
            w_rs1          = 1'b1;
            w_rs2          = 1'b1;
            w_ill          = i_funct7_5 & (i_funct3 != 3'b000)
                                        & (i_funct3 != 3'b101);
         end
         OP_OPIMM: begin
            w_c.RegWrite   = 1'b1;
            w_c.ALUSrcB    = 1'b1;
            w_c.ALUControl = alu_decode(i_funct3,
                                i_funct7_5 & (i_funct3 == 3'b101));
            w_rs1          = 1'b1;
            w_ill          = i_funct7_5 & (i_funct3 == 3'b001);
         end
         OP_LOAD: begin
            w_c.RegWrite  = 1'b1;
            w_c.ResultSrc = RES_MEM;
            w_c.ALUSrcB   = 1'b1;
            w_rs1         = 1'b1;
            w_ill         = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
         end
         OP_STORE: begin
            w_c.MemWrite = 1'b1;
            w_c.ALUSrcB  = 1'b1;
            w_imm        = IMM_S;
            w_rs1        = 1'b1;
            w_rs2        = 1'b1;
            w_ill        = i_funct3[2] | (i_funct3[1:0] == 2'b11);
         end
         OP_BRANCH: begin
            w_c.Branch     = 1'b1;
            w_c.ALUControl = ALU_SUB;
            w_imm          = IMM_B;
            w_rs1          = 1'b1;
            w_rs2          = 1'b1;
            w_ill          = (i_funct3[2:1] == 2'b01);
         end
         OP_JAL: begin
            w_c.RegWrite  = 1'b1;
            w_c.ResultSrc = RES_PC4;
            w_c.Jump      = 1'b1;
            w_c.ALUSrcA   = 1'b1;
            w_c.ALUSrcB   = 1'b1;
            w_imm         = IMM_J;
         end
         OP_JALR: begin
            w_c.RegWrite  = 1'b1;
            w_c.ResultSrc = RES_PC4;
            w_c.Jump      = 1'b1;
            w_c.Jalr      = 1'b1;
            w_c.ALUSrcB   = 1'b1;
            w_rs1         = 1'b1;
            w_ill         = (i_funct3 != 3'b000);
         end
         OP_LUI: begin
            w_c.RegWrite  = 1'b1;
            w_c.ResultSrc = RES_IMM;
            w_c.ALUSrcB   = 1'b1;
            w_imm         = IMM_U;
         end
         OP_AUIPC: begin
            w_c.RegWrite = 1'b1;
            w_c.ALUSrcA  = 1'b1;
            w_c.ALUSrcB  = 1'b1;
            w_imm        = IMM_U;
         end
         OP_FENCE, OP_SYSTEM: begin
            w_rs1 = 1'b1;
            w_ill = (i_funct3 != 3'b000);
         end
         default: begin
            w_ill = 1'b1;
         end
      endcase
      if (w_ill) begin
         w_c   = '0;
         w_imm = IMM_I;
         w_rs1 = 1'b0;
         w_rs2 = 1'b0;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      w_c.Illegal = w_ill;
`endif
   end

   assign o_Ctrl    = w_c;
   assign o_ImmSrc  = w_imm;
   assign o_UsesRs1 = w_rs1;
   assign o_UsesRs2 = w_rs2;

endmodule

// File: rtl/ctrl_pipeline.sv
// RV32I control unit: D decode, E/M/W control registers, E branch resolve.
// CTRL_ILLEGAL_TRAP_EN: when defined, illegal flag travels to o_IllegalW.
module ctrl_pipeline
   import ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int FUNCT3_TO_W = 1
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [6:0]            i_OpCode,
   input  logic [2:0]            i_funct3,
   input  logic                  i_funct7_5,
   input  logic                  i_FlushE,
   input  logic                  i_ZeroE,
   input  logic                  i_LtE,
   input  logic                  i_LtuE,
   output logic [2:0]            o_ImmSrcD,
   output logic                  o_UsesRs1D,
   output logic                  o_UsesRs2D,
   output logic                  o_IllegalD,
   output logic [ALU_CTRL_W-1:0] o_ALUControlE,
   output logic                  o_ALUSrcAE,
   output logic                  o_ALUSrcBE,
   output logic [1:0]            o_ResultSrcE,
   output logic                  o_JalrE,
   output logic                  o_PCSrcE,
   output logic                  o_RegWriteM,
   output logic                  o_MemWriteM,
   output logic [1:0]            o_ResultSrcM,
   output logic [2:0]            o_Funct3M,
   output logic                  o_RegWriteW,
   output logic [1:0]            o_ResultSrcW,
   output logic [2:0]            o_Funct3W,
   output logic                  o_IllegalW
);

   ctrl_bundle_t w_CtrlD;
   ctrl_bundle_t r_E;
   ctrl_bundle_t r_M;
   ctrl_bundle_t r_W;
   logic         w_TakenE;
   logic         w_unused;

   ctrl_decode u_decode (
      .i_OpCode   (i_OpCode),
      .i_funct3   (i_funct3),
      .i_funct7_5 (i_funct7_5),
      .o_Ctrl     (w_CtrlD),
      .o_ImmSrc   (o_ImmSrcD),
      .o_UsesRs1  (o_UsesRs1D),
      .o_UsesRs2  (o_UsesRs2D)
   );

   assign o_IllegalD = w_CtrlD.Illegal;

   // D->E register; reset beats flush, flush inserts a bubble
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_E <= '0;
      else if (i_FlushE)
         r_E <= '0;
      else
         r_E <= w_CtrlD;
   end

   // E->M register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_M <= '0;
      else
         r_M <= r_E;
   end

   // M->W register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_W <= '0;
      else
         r_W <= r_M;
   end

   // Branch condition from ALU flags; reserved funct3 never taken
   always_comb begin
      w_TakenE = 1'b0;
      unique case (r_E.funct3)
         3'b000:  w_TakenE = i_ZeroE;
         3'b001:  w_TakenE = ~i_ZeroE;
         3'b100:  w_TakenE = i_LtE;
         3'b101:  w_TakenE = ~i_LtE;
         3'b110:  w_TakenE = i_LtuE;
         3'b111:  w_TakenE = ~i_LtuE;
         default: w_TakenE = 1'b0;
      endcase
   end

   assign o_PCSrcE      = (r_E.Branch & w_TakenE) | r_E.Jump;
   assign o_ALUControlE = ALU_CTRL_W'(r_E.ALUControl);
   assign o_ALUSrcAE    = r_E.ALUSrcA;
   assign o_ALUSrcBE    = r_E.ALUSrcB;
   assign o_ResultSrcE  = r_E.ResultSrc;
   assign o_JalrE       = r_E.Jalr;

   assign o_RegWriteM  = r_M.RegWrite;
   assign o_MemWriteM  = r_M.MemWrite;
   assign o_ResultSrcM = r_M.ResultSrc;
   assign o_Funct3M    = r_M.funct3;

   assign o_RegWriteW  = r_W.RegWrite;
   assign o_ResultSrcW = r_W.ResultSrc;

   generate
      if (FUNCT3_TO_W != 0) begin : g_f3w
         assign o_Funct3W = r_W.funct3;
      end else begin : g_nof3w
         assign o_Funct3W = 3'b000;
      end
   endgenerate

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign o_IllegalW = r_W.Illegal;
`else
   assign o_IllegalW = 1'b0;
`endif

   assign w_unused = ^{r_E, r_M, r_W};

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Parametrised successor to the single-stage decode control unit for the 5-stage pipelined RV32I core.
- Decodes the full RV32I base set: adds lui, auipc, jalr, all six branches, shifts, xor and sltu.
- Carries control through D/E/M/W pipeline registers with an E-stage flush.
- Resolves branch taken/not-taken in E from ALU flags; sits between the F/D register, hazard unit and datapath.

Parameters:
- ALU_CTRL_W, 4, width of ALU control bus; must be >=4, upper bits zero.
- FUNCT3_TO_W, 1, 1 = funct3 carried to W for load sign/zero extension; 0 = o_Funct3W tied 0.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  synchronous active-low reset
- i_OpCode  in  7  instruction[6:0] from D
- i_funct3  in  3  instruction[14:12]
- i_funct7_5  in  1  instruction[30]
- i_FlushE  in  1  from hazard unit; bubble into E
- i_ZeroE  in  1  ALU result == 0
- i_LtE  in  1  signed SrcA < SrcB
- i_LtuE  in  1  unsigned SrcA < SrcB
- o_ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- o_UsesRs1D  out  1  instruction reads rs1 (hazard unit)
- o_UsesRs2D  out  1  instruction reads rs2
- o_IllegalD  out  1  undecodable instruction
- o_ALUControlE  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- o_ALUSrcAE  out  1  1 = PC (auipc/jal), 0 = rs1
- o_ALUSrcBE  out  1  1 = ImmExt, 0 = rs2
- o_ResultSrcE  out  2  for load-use detection
- o_JalrE  out  1  branch target taken from ALU result
- o_PCSrcE  out  1  redirect fetch
- o_RegWriteM  out  1
- o_MemWriteM  out  1
- o_ResultSrcM  out  2
- o_Funct3M  out  3  access size
- o_RegWriteW  out  1
- o_ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4, 11 ImmExt (lui)
- o_Funct3W  out  3
- o_IllegalW  out  1

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is synchronous, active-low.
- D outputs are combinational from the instruction fields.
- E, M and W are registered 1, 2 and 3 cycles after D.
- Reset: every E/M/W register clears to 0 (NOP bubble) on the rising edge while i_rst_n=0, so all registered outputs and o_PCSrcE read 0.
  - Reset has priority over flush.
  - Reset mid-stream drops all in-flight control.
- i_FlushE=1: E register loads 0 next edge; M and W advance normally. The instruction in D is discarded.
- Flush together with a valid D instruction: flush wins.
- Stages never stall. F/D stalling is external; a repeated D instruction simply re-enters E.
- ALU decode:
  - R-type: funct3 with funct7_5 selects sub or sra.
  - I-type ALU: funct7_5 is considered only for the shift encodings (funct3=101).
  - Loads, stores, auipc and jal use add; branches use sub.
  - lui: ALU don't-care, drive add.
- Branch evaluation, E stage, combinational from flags:
  - beq Zero; bne !Zero; blt Lt; bge !Lt; bltu Ltu; bgeu !Ltu.
  - funct3 010/011 never taken.
- o_PCSrcE = (BranchE & cond) | JumpE, with JumpE covering jal and jalr. o_JalrE is 1 only for jalr.
- Operand usage: UsesRs1 for every class except lui, auipc and jal; UsesRs2 only for R-type, store and branch.
- Illegal instruction (opcode outside the RV32I base set, or a bad funct combination): all control bits 0 and o_IllegalD=1.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: o_IllegalD is carried to W as o_IllegalW, and o_IllegalW is not cleared by writeback. It is cleared only by reset or flush, the same as other bits.
- Undefined: o_IllegalD and o_IllegalW are tied 0. Illegal instructions still decode to all-zero control (silent NOP).

Decomposition:
- ctrl_pkg holds:
  - opcode localparams
  - ImmSrc, ALU op and ResultSrc enums
  - packed ctrl_bundle_t struct: RegWrite, ResultSrc, MemWrite, Jump, Jalr, Branch, ALUControl, ALUSrcA, ALUSrcB, funct3, Illegal
- One sub-module, ctrl_decode, does the combinational instruction-to-ctrl_bundle_t decode.
- The top level holds the three pipeline registers and the branch resolver.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles while an add is in D -> all E/M/W outputs 0; after release the add reaches o_RegWriteW=1 three cycles later.
- Flow: issue add, lw, sw, beq back-to-back -> o_ResultSrcW sequence 00, 01, then RegWrite 0 for sw and beq; o_MemWriteM=1 exactly in the sw's M cycle.
- Branch table: bltu in E with LtuE=1 -> PCSrcE=1; with LtuE=0 -> 0; bge with LtE=1 -> 0; funct3=010 -> 0.
- Flush: lw in D with i_FlushE=1 -> next cycle o_ResultSrcE=00 and o_RegWriteM=0 the following cycle.
- Decode: sra (funct7_5=1, funct3=101) -> o_ALUControlE=9; srai -> 9; lui -> o_ResultSrcW=11 and UsesRs1D=0; jalr -> JalrE=1 and PCSrcE=1.
- Illegal: opcode 0x7F with CTRL_ILLEGAL_TRAP_EN -> o_IllegalD=1, o_IllegalW=1 three cycles later, RegWriteW=0; without the macro -> both flags 0.
